// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding
// a small prefetch FIFO toward the decoder, with redirect flush support.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e          state_q;
  logic [31:0]     addr_q;
  logic            discard_q;
  logic [31:0]     mem_instr_q [FIFO_DEPTH];
  logic [31:0]     mem_pc_q    [FIFO_DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            push;
  logic            pop;
  logic            can_issue;
  logic [31:0]     tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    tgt     = {redirect_pc_i[31:2], 2'b00};
    pop     = (count_q != '0) && instr_ready_i;
    push    = (state_q == WAIT) && instr_rvalid_i &&
              !discard_q && !redirect_i;
    count_d = count_q;
    if (redirect_i)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
    can_issue = fetch_enable_i && (count_d < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= BOOT_ADDR;
      discard_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr_q[i] <= NOP_C;
        mem_pc_q[i]    <= BOOT_ADDR;
      end
    end else begin
      count_q <= count_d;
      if (redirect_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) begin
          mem_instr_q[wr_q] <= instr_rdata_i;
          mem_pc_q[wr_q]    <= addr_q;
          wr_q              <= ptr_inc(wr_q);
        end
        if (pop)
          rd_q <= ptr_inc(rd_q);
      end
      unique case (state_q)
        IDLE: begin
          if (redirect_i)
            addr_q <= tgt;
          if (fetch_enable_i && (redirect_i || count_q < DEPTH_C))
            state_q <= REQ;
        end
        REQ: begin
          if (redirect_i)
            addr_q <= tgt;
          if (instr_gnt_i) begin
            state_q   <= WAIT;
            discard_q <= redirect_i;
          end
        end
        WAIT: begin
          if (redirect_i) begin
            addr_q <= tgt;
            if (instr_rvalid_i) begin
              state_q   <= REQ;
              discard_q <= 1'b0;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (instr_rvalid_i) begin
            discard_q <= 1'b0;
            // a discarded response leaves addr_q already at the new target
            if (discard_q) begin
              state_q <= REQ;
            end else begin
              addr_q  <= addr_q + 32'd4;
              state_q <= can_issue ? REQ : IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_req_o   = (state_q == REQ);
  assign instr_addr_o  = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = mem_instr_q[rd_q];
  assign pc_o          = mem_pc_q[rd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, backpressure,
// redirect, address wrap and reset-in-flight scenarios.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_enable_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .BOOT_ADDR (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_enable_i(fetch_enable_i),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_enable_i = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_ready_i  = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'h0;
    tick();
    tick();
    chk("rst_req",   {31'b0, instr_req_o},   32'd0);
    chk("rst_addr",  instr_addr_o,           32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o,                32'h0000_0013);
    chk("rst_pc",    pc_o,                   32'h0);

    // first fetch: gnt with req, rvalid the next cycle
    rst_n          = 1'b1;
    fetch_enable_i = 1'b1;
    tick();
    chk("f0_req",  {31'b0, instr_req_o}, 32'd1);
    chk("f0_addr", instr_addr_o,         32'h0);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    chk("f0_wait_req", {31'b0, instr_req_o}, 32'd0);
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0010_0093;
    tick();
    instr_rvalid_i = 1'b0;
    chk("f0_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("f0_instr", instr_o,                32'h0010_0093);
    chk("f0_pc",    pc_o,                   32'h0);
    chk("f1_req",   {31'b0, instr_req_o},   32'd1);
    chk("f1_addr",  instr_addr_o,           32'h4);

    // fill FIFO while decoder stalls
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0020_0113;
    tick();
    instr_rvalid_i = 1'b0;
    chk("full_req",  {31'b0, instr_req_o},   32'd0);
    chk("full_head", pc_o,                   32'h0);
    chk("full_valid",{31'b0, instr_valid_o}, 32'd1);
    tick();
    tick();
    tick();
    chk("full_hold_req", {31'b0, instr_req_o}, 32'd0);
    chk("full_hold_pc",  pc_o,                 32'h0);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("pop_pc",    pc_o,                   32'h4);
    chk("pop_instr", instr_o,                32'h0020_0113);
    chk("pop_valid", {31'b0, instr_valid_o}, 32'd1);
    tick();
    chk("refill_req",  {31'b0, instr_req_o}, 32'd1);
    chk("refill_addr", instr_addr_o,         32'h8);

    // grant stall, then redirect during stall
    tick();
    tick();
    tick();
    chk("stall_req",  {31'b0, instr_req_o}, 32'd1);
    chk("stall_addr", instr_addr_o,         32'h8);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick();
    redirect_i = 1'b0;
    chk("stall_redir_req",   {31'b0, instr_req_o},   32'd1);
    chk("stall_redir_addr",  instr_addr_o,           32'h200);
    chk("stall_redir_valid", {31'b0, instr_valid_o}, 32'd0);

    // redirect while waiting for a response
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i   = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    chk("wait_redir_req",  {31'b0, instr_req_o}, 32'd0);
    chk("wait_redir_addr", instr_addr_o,         32'h100);
    tick();
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    tick();
    instr_rvalid_i = 1'b0;
    chk("drop_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("drop_req",   {31'b0, instr_req_o},   32'd1);
    chk("drop_addr",  instr_addr_o,           32'h100);

    // address wrap at top of memory
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("wrap_addr", instr_addr_o, 32'hFFFF_FFFC);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0000_0033;
    tick();
    instr_rvalid_i = 1'b0;
    chk("wrap_pc",    pc_o,                 32'hFFFF_FFFC);
    chk("wrap_instr", instr_o,              32'h0000_0033);
    chk("wrap_next",  instr_addr_o,         32'h0);
    chk("wrap_req",   {31'b0, instr_req_o}, 32'd1);

    // reset while a response is outstanding
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    rst_n       = 1'b0;
    tick();
    rst_n          = 1'b1;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0BAD_0BAD;
    tick();
    chk("rstw_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rstw_addr",  instr_addr_o,           32'h0);
    chk("rstw_instr", instr_o,                32'h0000_0013);
    chk("rstw_req",   {31'b0, instr_req_o},   32'd1);
    tick();
    instr_rvalid_i = 1'b0;
    chk("rv_in_req_valid", {31'b0, instr_valid_o}, 32'd0);

    // simultaneous push and pop
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hAAAA_0001;
    tick();
    instr_rvalid_i = 1'b0;
    chk("pp_a_pc", pc_o, 32'h0);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hBBBB_0002;
    instr_ready_i  = 1'b1;
    tick();
    instr_rvalid_i = 1'b0;
    chk("pp_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("pp_pc",    pc_o,                   32'h4);
    chk("pp_instr", instr_o,                32'hBBBB_0002);
    chk("pp_addr",  instr_addr_o,           32'h8);
    tick();
    instr_ready_i = 1'b0;
    chk("pp_empty", {31'b0, instr_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter FIFO_DEPTH, default 2, number of prefetch entries; legal values 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 fetch_enable_i  input  1  permits issue of new memory requests.
REQ-006 instr_req_o  output  1  instruction memory request.
REQ-007 instr_addr_o  output  32  request address, word aligned.
REQ-008 instr_gnt_i  input  1  memory accepted the request this cycle.
REQ-009 instr_rvalid_i  input  1  instr_rdata_i valid this cycle.
REQ-010 instr_rdata_i  input  32  fetched instruction word.
REQ-011 instr_valid_o  output  1  instr_o/pc_o hold a valid entry for the decoder.
REQ-012 instr_o  output  32  instruction word to the decoder's instr_i.
REQ-013 pc_o  output  32  address of instr_o.
REQ-014 instr_ready_i  input  1  decoder consumes the head entry.
REQ-015 redirect_i  input  1  taken branch or jump; flush and refetch.
REQ-016 redirect_pc_i  input  32  new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-017 State machine: IDLE (no request), REQ (instr_req_o=1, awaiting gnt), WAIT (granted, awaiting rvalid); at most one outstanding request.
REQ-018 IDLE->REQ next cycle when fetch_enable_i=1 and FIFO count < FIFO_DEPTH; otherwise remain IDLE.
REQ-019 instr_req_o SHALL be 1 exactly in REQ; instr_addr_o SHALL equal the fetch address register.
REQ-020 REQ->WAIT on instr_gnt_i=1; otherwise remain REQ regardless of fetch_enable_i.
REQ-021 WAIT with instr_rvalid_i=1: push {instr_rdata_i, fetch address} unless discard flag set, fetch address += 4 (mod 2^32 wrap); next state REQ if fetch_enable_i=1 and post-push count < FIFO_DEPTH, else IDLE.
REQ-022 instr_rvalid_i outside WAIT SHALL be ignored.
REQ-023 instr_valid_o = FIFO non-empty; instr_o/pc_o = head entry, registered, no combinational path from instr_rdata_i.
REQ-024 Pop when instr_valid_o=1 and instr_ready_i=1; head advances next cycle.
REQ-025 Simultaneous push and pop SHALL keep count unchanged; entries delivered strictly in fetch order.
REQ-026 FIFO overflow impossible by REQ-018/REQ-021; no push when full.
REQ-027 Minimum latency: rvalid at cycle N -> instr_valid_o=1 at cycle N+1 when FIFO empty.
REQ-028 redirect_i=1: next cycle FIFO empty (same-cycle pop and push dropped), fetch address = {redirect_pc_i[31:2],2'b00}.
REQ-029 Redirect in REQ with gnt=0: stay REQ, instr_addr_o shows new target next cycle (memory samples address only with gnt).
REQ-030 Redirect in REQ with gnt=1, or in WAIT with rvalid=0: set discard flag; the pending response is dropped, then flag cleared and state REQ at new target.
REQ-031 Redirect in WAIT with rvalid=1: response dropped, no discard flag, next state REQ.
REQ-032 Redirect in IDLE: next state REQ if fetch_enable_i=1.
REQ-033 fetch_enable_i=0 SHALL stop only new issue; outstanding response completes and is pushed.

Reset
REQ-034 rst_n=0 at a clock edge: state IDLE, FIFO empty, discard flag 0, fetch address BOOT_ADDR, overriding any in-flight request or redirect.
REQ-035 Reset outputs: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=BOOT_ADDR.
REQ-036 A response arriving after reset mid-WAIT SHALL be ignored.

Verification
REQ-037 Reset, enable, gnt same cycle as req, rvalid next cycle, rdata=32'h0010_0093 -> instr_valid_o with instr_o=32'h0010_0093, pc_o=0; next request addr 0x4.
REQ-038 instr_ready_i=0 held, depth 2 -> exactly 2 entries (pc 0x0, 0x4), instr_req_o stays 0; one pop -> request to 0x8 issued.
REQ-039 Redirect to 0x0000_0103 while in WAIT, rvalid 2 cycles later -> that word dropped, FIFO empty, next request addr 0x0000_0100.
REQ-040 gnt held 0 for 3 cycles -> req and addr stable; redirect during stall -> addr changes to target, req stays 1.
REQ-041 Fetch at 0xFFFF_FFFC completes -> next address 0x0000_0000.
REQ-042 rst_n=0 during WAIT, rvalid in following cycle -> no push, instr_valid_o=0, instr_addr_o=BOOT_ADDR.
